// File: rtl/character_unpacker_if.sv
// Handshake bundle between the packed-character source, the unpacker and
// the downstream text/command writer.
interface character_unpacker_if;
  logic [31:0] word_in;
  logic        load;
  logic        busy;
  logic [7:0]  char_out;
  logic        char_valid;
  logic        char_ready;
  logic        done;
  logic [2:0]  count;

  // Side that supplies words and consumes characters
  modport master (
    output word_in, load, char_ready,
    input  busy, char_out, char_valid, done, count
  );

  // The unpacker itself
  modport slave (
    input  word_in, load, char_ready,
    output busy, char_out, char_valid, done, count
  );
endinterface

// File: rtl/character_unpacker.sv
// Serialises a 32-bit packed-character word into bytes, oldest (MSB) first,
// one per valid/ready handshake. Null bytes are optionally dropped silently.
module character_unpacker #(
  parameter bit SKIP_NULL = 1'b1
) (
  input logic                 clock,
  input logic                 reset,
  character_unpacker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t      state;
  logic [31:0] sreg;
  logic [2:0]  rem;
  logic [2:0]  count;

  logic [7:0]  top;
  logic        skip;
  logic        valid;
  logic        shift;

  // The offered byte is always the top of the shift register; nothing here
  // depends on char_ready, so valid/data come straight from registers.
  assign top   = sreg[31:24];
  assign skip  = SKIP_NULL && (top == 8'h00);
  assign valid = (state == SEND) && !skip;
  // Advance on a skipped null (ready ignored) or on a completed handshake
  assign shift = (state == SEND) && (skip || bus.char_ready);

  // Control FSM together with the shift register and counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sreg  <= 32'h0;
      rem   <= 3'd0;
      count <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load) begin
            sreg  <= bus.word_in;
            rem   <= 3'd4;
            count <= 3'd0;
            state <= SEND;
          end
        end
        SEND: begin
          if (shift) begin
            sreg <= {sreg[23:0], 8'h00};
            rem  <= rem - 3'd1;
            if (!skip) begin
              count <= count + 3'd1;
            end
            if (rem == 3'd1) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          // Loads arriving here are dropped because busy is still high
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.char_out   = top;
  assign bus.char_valid = valid;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.count      = count;

endmodule

// File: tb/tb_character_unpacker.sv
// Scoreboard bench: two unpackers (nulls skipped / nulls emitted) share the
// same stimulus; expected bytes and counts are queued at load time and a
// negedge monitor pops and compares whenever a DUT hands over a byte or
// pulses done.
module tb_character_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] word_in;
  logic        load;
  logic        char_ready;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q1[$];
  logic [7:0] q0[$];
  logic [2:0] qc1[$];
  logic [2:0] qc0[$];
  bit         pv[2];
  logic [7:0] pc[2];
  bit         pd[2];

  always #5 clk = ~clk;

  character_unpacker_if if1();
  character_unpacker_if if0();

  assign if1.word_in    = word_in;
  assign if1.load       = load;
  assign if1.char_ready = char_ready;
  assign if0.word_in    = word_in;
  assign if0.load       = load;
  assign if0.char_ready = char_ready;

  character_unpacker #(.SKIP_NULL(1'b1)) u_dut1 (.clock(clk), .reset(rst_n), .bus(if1));
  character_unpacker #(.SKIP_NULL(1'b0)) u_dut0 (.clock(clk), .reset(rst_n), .bus(if0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event with nothing expected (t=%0t)", name, $time);
  endtask

  // Reference model: byte order MSB first, nulls dropped when skipping
  task automatic model_push(input logic [31:0] w);
    logic [7:0] b;
    logic [2:0] n1;
    n1 = 3'd0;
    for (int i = 3; i >= 0; i--) begin
      b = w[i*8 +: 8];
      q0.push_back(b);
      if (b != 8'h00) begin
        q1.push_back(b);
        n1 = n1 + 3'd1;
      end
    end
    qc1.push_back(n1);
    qc0.push_back(3'd4);
  endtask

  task automatic mon(input int k, input logic v, input logic [7:0] d, input logic dn,
                     input logic bz, input logic [2:0] c);
    logic [7:0] e;
    logic [2:0] ec;
    if (v && char_ready) begin
      if ((k == 1 ? q1.size() : q0.size()) == 0) fail_evt(k == 1 ? "char1" : "char0");
      else begin
        e = (k == 1) ? q1.pop_front() : q0.pop_front();
        chk(k == 1 ? "char1" : "char0", {24'h0, d}, {24'h0, e});
      end
    end
    if (pv[k]) begin
      chk("hold_valid", {31'h0, v}, 32'h1);
      chk("hold_char", {24'h0, d}, {24'h0, pc[k]});
    end
    if (dn) begin
      if ((k == 1 ? qc1.size() : qc0.size()) == 0) fail_evt(k == 1 ? "done1" : "done0");
      else begin
        ec = (k == 1) ? qc1.pop_front() : qc0.pop_front();
        chk(k == 1 ? "count1" : "count0", {29'h0, c}, {29'h0, ec});
      end
    end
    if (pd[k]) chk("busy_after_done", {31'h0, bz}, 32'h0);
    pv[k] = v && !char_ready;
    pc[k] = d;
    pd[k] = dn;
  endtask

  // Monitor: sample both DUTs away from the active edge
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      mon(1, if1.char_valid, if1.char_out, if1.done, if1.busy, if1.count);
      mon(0, if0.char_valid, if0.char_out, if0.done, if0.busy, if0.count);
    end
  end

  // mode 0: ready high, 1: 3 low / 1 high, 2: random. exp_done 0 = unchecked.
  task automatic run_word(input logic [31:0] w, input int mode, input int exp_done,
                          input int busy_load_cyc);
    int dc1, dc0;
    dc1 = 0;
    dc0 = 0;
    model_push(w);
    word_in    = w;
    load       = 1'b1;
    char_ready = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      case (mode)
        0:       char_ready = 1'b1;
        1:       char_ready = ((cyc % 4) == 0);
        default: char_ready = 1'($urandom_range(0, 1));
      endcase
      if (cyc == busy_load_cyc) begin
        word_in = 32'h5A5A5A5A;
        load    = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
      if (if1.done && dc1 == 0) dc1 = cyc;
      if (if0.done && dc0 == 0) dc0 = cyc;
      @(posedge clk);
      #1;
      if (dc1 != 0 && dc0 != 0) break;
    end
    load = 1'b0;
    if (dc1 == 0) fail_evt("timeout1");
    if (dc0 == 0) fail_evt("timeout0");
    if (exp_done != 0) begin
      chk("done_cycle1", dc1, exp_done);
      chk("done_cycle0", dc0, exp_done);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid1"}, {31'h0, if1.char_valid}, 32'h0);
    chk({tag, "_busy1"},  {31'h0, if1.busy}, 32'h0);
    chk({tag, "_done1"},  {31'h0, if1.done}, 32'h0);
    chk({tag, "_count1"}, {29'h0, if1.count}, 32'h0);
    chk({tag, "_char1"},  {24'h0, if1.char_out}, 32'h0);
    chk({tag, "_valid0"}, {31'h0, if0.char_valid}, 32'h0);
    chk({tag, "_busy0"},  {31'h0, if0.busy}, 32'h0);
    chk({tag, "_count0"}, {29'h0, if0.count}, 32'h0);
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  b;
    int          mode;
    rst_n      = 1'b0;
    load       = 1'b0;
    char_ready = 1'b0;
    word_in    = 32'h0;
    #12;
    chk_idle_outputs("reset");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    run_word(32'h41424344, 0, 5, 0);
    run_word(32'h00004142, 0, 5, 0);
    run_word(32'h61626364, 1, 17, 0);
    run_word(32'h00000000, 0, 5, 0);
    run_word(32'h31323334, 0, 5, 2);

    // Asynchronous reset mid-word, after two bytes have gone out
    model_push(32'h41424344);
    word_in    = 32'h41424344;
    load       = 1'b1;
    char_ready = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("count_mid1", {29'h0, if1.count}, 32'h2);
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    q1.delete();
    q0.delete();
    qc1.delete();
    qc0.delete();
    pv = '{default: 1'b0};
    pd = '{default: 1'b0};
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_word(32'h71727374, 0, 5, 0);

    // Randomised words with random nulls, backpressure and stray loads
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) begin
        b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        w[i*8 +: 8] = b;
      end
      mode = $urandom_range(0, 2);
      run_word(w, mode, (mode == 0) ? 5 : 0, ($urandom_range(0, 3) == 0) ? 2 : 0);
    end

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("queues_empty", q1.size() + q0.size() + qc1.size() + qc0.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
